ps2_scan_decoder: RTL and testbench

Consumes raw scan-code bytes from the PS/2 receiver's FIFO (`data`/`ready`/`nextdata_n` handshake) and turns Set-2 byte sequences into key events. Strips `E0`/`F0` prefixes and tracks the currently held key and modifier state (shift, caps lock). Counts distinct key presses and optionally produces ASCII. Sits directly downstream of the PS/2 receiver and feeds display/console logic.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_scan_decoder_if.sv | 23 ++
 rtl/ps2_scan2ascii.sv | 70 +++++++
 rtl/ps2_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and Set-2 scan-code constants for the PS/2 scan decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Two-phase byte handshake: sample in S_IDLE, pop and decode in S_POP.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_POP  = 1'b1
    } state_e;

    // A key is identified by its code plus whether it carried an E0 prefix.
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte handshake between the PS/2 receiver FIFO and the scan decoder.
// Latency: n/a (wires only).
// Backpressure: consumer pops the head byte by pulsing kb_nextdata_n low for one cycle.
//   kb_data       : scan byte at the FIFO head, valid while kb_ready
//   kb_ready      : FIFO non-empty
//   kb_nextdata_n : active-low pop request from the consumer
interface ps2_scan_decoder_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_nextdata_n;

    modport master (
        output kb_data,
        output kb_ready,
        input  kb_nextdata_n
    );

    modport slave (
        input  kb_data,
        input  kb_ready,
        output kb_nextdata_n
    );
endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational Set-2 scan code to ASCII lookup, present only when PS2_DECODER_ASCII_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   code_i  : Set-2 scan code (prefixes already stripped)
//   upper_i : shift XOR caps, selects letter case
//   shift_i : a shift key is held; digits only map when unshifted
//   ascii_o : ASCII character, 0 when the code has no mapping
`ifdef PS2_DECODER_ASCII_EN
module ps2_scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       upper_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);

    // 1..26 for a..z, 0 when not a letter
    logic [4:0] letter_idx;
    // 1..10 for 0..9, 0 when not a digit
    logic [3:0] digit_idx;

    always_comb begin
        letter_idx = 5'd0;
        case (code_i)
            8'h1C: letter_idx = 5'd1;   8'h32: letter_idx = 5'd2;
            8'h21: letter_idx = 5'd3;   8'h23: letter_idx = 5'd4;
            8'h24: letter_idx = 5'd5;   8'h2B: letter_idx = 5'd6;
            8'h34: letter_idx = 5'd7;   8'h33: letter_idx = 5'd8;
            8'h43: letter_idx = 5'd9;   8'h3B: letter_idx = 5'd10;
            8'h42: letter_idx = 5'd11;  8'h4B: letter_idx = 5'd12;
            8'h3A: letter_idx = 5'd13;  8'h31: letter_idx = 5'd14;
            8'h44: letter_idx = 5'd15;  8'h4D: letter_idx = 5'd16;
            8'h15: letter_idx = 5'd17;  8'h2D: letter_idx = 5'd18;
            8'h1B: letter_idx = 5'd19;  8'h2C: letter_idx = 5'd20;
            8'h3C: letter_idx = 5'd21;  8'h2A: letter_idx = 5'd22;
            8'h1D: letter_idx = 5'd23;  8'h22: letter_idx = 5'd24;
            8'h35: letter_idx = 5'd25;  8'h1A: letter_idx = 5'd26;
            default: letter_idx = 5'd0;
        endcase
    end

    always_comb begin
        digit_idx = 4'd0;
        case (code_i)
            8'h45: digit_idx = 4'd1;    8'h16: digit_idx = 4'd2;
            8'h1E: digit_idx = 4'd3;    8'h26: digit_idx = 4'd4;
            8'h25: digit_idx = 4'd5;    8'h2E: digit_idx = 4'd6;
            8'h36: digit_idx = 4'd7;    8'h3D: digit_idx = 4'd8;
            8'h3E: digit_idx = 4'd9;    8'h46: digit_idx = 4'd10;
            default: digit_idx = 4'd0;
        endcase
    end

    // Indices are 1-based so the base values sit one below 'A'/'a'/'0'.
    always_comb begin
        ascii_o = 8'h00;
        if (letter_idx != 5'd0) begin
            ascii_o = (upper_i ? 8'h40 : 8'h60) + {3'b000, letter_idx};
        end else if (digit_idx != 4'd0) begin
            ascii_o = shift_i ? 8'h00 : (8'h2F + {4'b0000, digit_idx});
        end else if (code_i == SC_SPACE) begin
            ascii_o = 8'h20;
        end else if (code_i == SC_ENTER) begin
            ascii_o = 8'h0D;
        end
    end

endmodule
`endif

// File: rtl/ps2_scan_decoder.sv
// Turns Set-2 scan bytes from the PS/2 receiver FIFO into key events with held-key, modifier and press-count tracking.
// Latency: event outputs and key_valid appear 2 cycles after kb_ready is sampled; one byte per 2 cycles.
// Backpressure: pops only when kb_ready is high; kb_nextdata_n is a registered single-cycle low pulse.
//   clk, rst        : system clock, synchronous active-high reset
//   kb (slave)      : kb_data / kb_ready / kb_nextdata_n receiver handshake
//   key_valid       : one-cycle event pulse; key_code/key_ext/key_release/key_repeat describe the event
//   key_down, shift, caps, press_count : tracked state, updated with each event
//   ascii           : ASCII for the last event; only generated when PS2_DECODER_ASCII_EN is defined, else 0
module ps2_scan_decoder
    import ps2_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ps2_scan_decoder_if.slave  kb,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_release,
    output logic               key_repeat,
    output logic               key_down,
    output logic [7:0]         ascii,
    output logic               shift,
    output logic               caps,
    output logic [7:0]         press_count
);

    state_e     state_q;
    logic       nextdata_n_q;
    logic [7:0] byte_q;
    logic       ext_q;
    logic       brk_q;
    key_id_t    held_q;
    logic       lshift_q;
    logic       rshift_q;

    logic       key_valid_q;
    logic [7:0] key_code_q;
    logic       key_ext_q;
    logic       key_release_q;
    logic       key_repeat_q;
    logic       key_down_q;
    logic       caps_q;
    logic [7:0] press_count_q;

    key_id_t    cur_key;
    logic       same_key;
    key_id_t    held_d;
    logic       key_down_d;
    logic       key_repeat_d;
    logic       caps_d;
    logic       lshift_d;
    logic       rshift_d;
    logic [7:0] press_count_d;

    // Next tracking state assuming byte_q is a non-prefix byte; only
    // committed by the FSM in S_POP when that is actually the case.
    always_comb begin
        cur_key       = '{ext: ext_q, code: byte_q};
        same_key      = (cur_key == held_q);
        held_d        = held_q;
        key_down_d    = key_down_q;
        key_repeat_d  = 1'b0;
        caps_d        = caps_q;
        lshift_d      = lshift_q;
        rshift_d      = rshift_q;
        press_count_d = press_count_q;

        if (!brk_q) begin
            // A make of the key already held is typematic repeat: no new press.
            if (same_key && key_down_q) begin
                key_repeat_d = 1'b1;
            end else begin
                held_d        = cur_key;
                key_down_d    = 1'b1;
                press_count_d = press_count_q + 8'd1;
                if (byte_q == SC_CAPS) begin
                    caps_d = ~caps_q;
                end
            end
        end else if (same_key) begin
            key_down_d = 1'b0;
        end

        if (!ext_q && (byte_q == SC_LSHIFT)) begin
            lshift_d = ~brk_q;
        end
        if (!ext_q && (byte_q == SC_RSHIFT)) begin
            rshift_d = ~brk_q;
        end
    end

`ifdef PS2_DECODER_ASCII_EN
    logic [7:0] lut_ascii;
    logic [7:0] ascii_d;
    logic [7:0] ascii_q;

    // Modifier state before this event; a letter or digit never changes it.
    ps2_scan2ascii u_scan2ascii (
        .code_i  (byte_q),
        .upper_i ((lshift_q | rshift_q) ^ caps_q),
        .shift_i (lshift_q | rshift_q),
        .ascii_o (lut_ascii)
    );

    assign ascii_d = ext_q ? 8'h00 : lut_ascii;
    assign ascii   = ascii_q;
`else
    assign ascii = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            nextdata_n_q  <= 1'b1;
            byte_q        <= 8'h00;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            held_q        <= '0;
            lshift_q      <= 1'b0;
            rshift_q      <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_down_q    <= 1'b0;
            caps_q        <= 1'b0;
            press_count_q <= 8'h00;
`ifdef PS2_DECODER_ASCII_EN
            ascii_q       <= 8'h00;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (kb.kb_ready) begin
                        byte_q       <= kb.kb_data;
                        nextdata_n_q <= 1'b0;
                        state_q      <= S_POP;
                    end
                end
                S_POP: begin
                    nextdata_n_q <= 1'b1;
                    state_q      <= S_IDLE;
                    if (byte_q == SC_E0) begin
                        ext_q <= 1'b1;
                    end else if (byte_q == SC_F0) begin
                        brk_q <= 1'b1;
                    end else begin
                        key_valid_q   <= 1'b1;
                        key_code_q    <= byte_q;
                        key_ext_q     <= ext_q;
                        key_release_q <= brk_q;
                        key_repeat_q  <= key_repeat_d;
                        key_down_q    <= key_down_d;
                        held_q        <= held_d;
                        caps_q        <= caps_d;
                        lshift_q      <= lshift_d;
                        rshift_q      <= rshift_d;
                        press_count_q <= press_count_d;
`ifdef PS2_DECODER_ASCII_EN
                        ascii_q       <= ascii_d;
`endif
                        ext_q         <= 1'b0;
                        brk_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    nextdata_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign kb.kb_nextdata_n = nextdata_n_q;
    assign key_valid        = key_valid_q;
    assign key_code         = key_code_q;
    assign key_ext          = key_ext_q;
    assign key_release      = key_release_q;
    assign key_repeat       = key_repeat_q;
    assign key_down         = key_down_q;
    assign shift            = lshift_q | rshift_q;
    assign caps             = caps_q;
    assign press_count      = press_count_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: emulates the receiver FIFO and compares every cycle against a key-event model.
// Latency: n/a.
// Backpressure: the emulated FIFO pops its head whenever kb_nextdata_n is seen low outside reset.
module tb_ps2_scan_decoder;

`ifdef PS2_DECODER_ASCII_EN
    localparam bit ASCII_EN = 1'b1;
`else
    localparam bit ASCII_EN = 1'b0;
`endif
    localparam logic [7:0] A_LOW = ASCII_EN ? 8'h61 : 8'h00;
    localparam logic [7:0] A_UP  = ASCII_EN ? 8'h41 : 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid, key_ext, key_release, key_repeat, key_down, shift, caps;
    logic [7:0] key_code, ascii, press_count;

    ps2_scan_decoder_if kb_if ();

    ps2_scan_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .kb          (kb_if),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .key_down    (key_down),
        .ascii       (ascii),
        .shift       (shift),
        .caps        (caps),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         ext, rel, rep, down, shift, caps;
        logic [7:0] ascii;
        logic [7:0] count;
    } ev_t;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [12]         = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h12, 8'h59, 8'h58, 8'h29, 8'h5A,
                                      8'h75, 8'h66};

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int pops = 0;
    int rst_hits = 0;
    logic [2:0] rep_hist = 3'b000;

    logic [7:0] fifo [$];
    bit  rst_cmd = 1'b1;
    bit  rst_q = 1'b1;
    bit  rst_pop_req = 1'b0;
    bit  e_nd_low = 1'b0;

    // Model state
    bit       m_ext, m_brk, m_down, m_lsh, m_rsh, m_caps;
    bit [8:0] m_held;
    bit [7:0] m_count;
    ev_t      exp_ev, pend_ev;
    bit       pend = 1'b0;
    bit       exp_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit ext,
                                               input bit upper, input bit shifted);
        logic [7:0] a;
        a = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) a = (upper ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code && !shifted) a = 8'h30 + 8'(i);
        if (code == 8'h29) a = 8'h20;
        if (code == 8'h5A) a = 8'h0D;
        if (ext) a = 8'h00;
        return ASCII_EN ? a : 8'h00;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_down = 0; m_lsh = 0; m_rsh = 0; m_caps = 0;
        m_held = '0; m_count = '0;
        exp_ev = '{default: '0};
        pend = 0;
        exp_vld = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit [8:0] key;
        bit       shifted;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            key     = {m_ext, b};
            shifted = m_lsh | m_rsh;
            pend_ev.ascii = model_ascii(b, m_ext, shifted ^ m_caps, shifted);
            pend_ev.rep   = 0;
            if (!m_brk) begin
                if (m_down && key == m_held) begin
                    pend_ev.rep = 1;
                end else begin
                    m_held = key;
                    m_down = 1;
                    m_count = m_count + 8'd1;
                    if (b == 8'h58) m_caps = !m_caps;
                end
            end else if (key == m_held) begin
                m_down = 0;
            end
            if (!m_ext && b == 8'h12) m_lsh = !m_brk;
            if (!m_ext && b == 8'h59) m_rsh = !m_brk;
            pend_ev.code  = b;
            pend_ev.ext   = m_ext;
            pend_ev.rel   = m_brk;
            pend_ev.down  = m_down;
            pend_ev.shift = m_lsh | m_rsh;
            pend_ev.caps  = m_caps;
            pend_ev.count = m_count;
            pend = 1;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // One clock: compare, then act as the receiver FIFO for the next edge.
    task automatic cycle();
        @(negedge clk);
        if (rst_q) begin
            model_reset();
        end else begin
            exp_vld = pend;
            if (pend) exp_ev = pend_ev;
            pend = 0;
        end
        check("key_valid", key_valid, exp_vld);
        check("key_code", key_code, exp_ev.code);
        check("key_ext", key_ext, exp_ev.ext);
        check("key_release", key_release, exp_ev.rel);
        check("key_repeat", key_repeat, exp_ev.rep);
        check("key_down", key_down, exp_ev.down);
        check("ascii", ascii, exp_ev.ascii);
        check("shift", shift, exp_ev.shift);
        check("caps", caps, exp_ev.caps);
        check("press_count", press_count, exp_ev.count);
        check("kb_nextdata_n", kb_if.kb_nextdata_n, !e_nd_low);
        if (key_valid === 1'b1) begin
            pulses++;
            rep_hist = {rep_hist[1:0], key_repeat};
        end
        if (rst_pop_req && kb_if.kb_nextdata_n === 1'b0) begin
            rst_cmd = 1;
            rst_pop_req = 0;
            rst_hits++;
        end
        rst = rst_cmd;
        if (kb_if.kb_nextdata_n === 1'b0 && !rst && fifo.size() > 0) begin
            pops++;
            model_byte(fifo.pop_front());
        end
        kb_if.kb_ready = (fifo.size() > 0);
        kb_if.kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
        e_nd_low = !rst && !e_nd_low && kb_if.kb_ready;
        rst_q = rst;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (fifo.size() > 0 && n < 10000) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check("drain_done", fifo.size(), 0);
    endtask

    task automatic do_reset();
        rst_cmd = 1;
        repeat (3) cycle();
        rst_cmd = 0;
        cycle();
    endtask

    int p0, q0, n;
    logic [7:0] c;

    initial begin
        kb_if.kb_ready = 1'b0;
        kb_if.kb_data  = 8'h00;
        model_reset();

        // Reset state
        do_reset();
        check("rst_code", key_code, 8'h00);
        check("rst_count", press_count, 8'h00);
        check("rst_nd", kb_if.kb_nextdata_n, 1'b1);
        check("rst_down", key_down, 1'b0);

        // Single make
        p0 = pulses; q0 = pops;
        push(8'h1C); drain();
        check("t1_pulses", pulses - p0, 1);
        check("t1_pops", pops - q0, 1);
        check("t1_code", key_code, 8'h1C);
        check("t1_ascii", ascii, A_LOW);
        check("t1_down", key_down, 1'b1);
        check("t1_count", press_count, 8'd1);

        // Break
        p0 = pulses; q0 = pops;
        push(8'hF0); push(8'h1C); drain();
        check("t2_pulses", pulses - p0, 1);
        check("t2_pops", pops - q0, 2);
        check("t2_release", key_release, 1'b1);
        check("t2_down", key_down, 1'b0);
        check("t2_count", press_count, 8'd1);

        // Shift and caps
        push(8'h12); push(8'h1C); drain();
        check("t3_shift_ascii", ascii, A_UP);
        check("t3_shift", shift, 1'b1);
        push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12); drain();
        check("t3_shift_off", shift, 1'b0);
        push(8'h58); push(8'hF0); push(8'h58); push(8'h1C); drain();
        check("t3_caps_ascii", ascii, A_UP);
        check("t3_caps_on", caps, 1'b1);
        push(8'h58); push(8'h58); drain();
        check("t3_caps_once", caps, 1'b0);
        check("t3_caps_rep", key_repeat, 1'b1);
        push(8'hF0); push(8'h58); drain();

        // Extended keys
        do_reset();
        p0 = pulses;
        push(8'hE0); push(8'h75); drain();
        check("t4_pulses", pulses - p0, 1);
        check("t4_ext", key_ext, 1'b1);
        check("t4_ascii", ascii, 8'h00);
        check("t4_code", key_code, 8'h75);
        p0 = pulses;
        push(8'hE0); push(8'hF0); push(8'h75); drain();
        check("t4b_pulses", pulses - p0, 1);
        check("t4b_ext", key_ext, 1'b1);
        check("t4b_release", key_release, 1'b1);

        // Typematic repeat
        do_reset();
        p0 = pulses; rep_hist = 3'b000;
        push(8'h1C); push(8'h1C); push(8'h1C); drain();
        check("t5_pulses", pulses - p0, 3);
        check("t5_repeat_seq", rep_hist, 3'b011);
        check("t5_count", press_count, 8'd1);

        // press_count wrap
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
        drain();
        check("t6_pulses", pulses - p0, 256);
        check("t6_count_wrap", press_count, 8'd0);

        // Reset during S_POP
        do_reset();
        p0 = pulses; q0 = pops; rst_hits = 0;
        rst_pop_req = 1;
        push(8'h1C); push(8'h32); push(8'h21); push(8'h23);
        push(8'h24); push(8'h2B); push(8'h34); push(8'h33);
        n = 0;
        while (rst_hits == 0 && n < 50) begin
            cycle();
            n++;
        end
        check("t7_rst_hit", rst_hits, 1);
        cycle(); cycle();
        check("t7_fifo_kept", fifo.size(), 8);
        check("t7_rst_nd", kb_if.kb_nextdata_n, 1'b1);
        check("t7_rst_code", key_code, 8'h00);
        rst_cmd = 0;
        drain();
        check("t7_pops", pops - q0, 8);
        check("t7_pulses", pulses - p0, 8);
        check("t7_count", press_count, 8'd8);
        check("t7_code", key_code, 8'h33);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 12) == 12) begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'hE0 || c == 8'hF0) c = 8'h66;
            end else begin
                c = pool[$urandom_range(0, 11)];
            end
            if ($urandom_range(0, 4) == 0) push(8'hE0);
            if ($urandom_range(0, 9) < 4) push(8'hF0);
            push(c);
            if ($urandom_range(0, 3) == 0) push(c);
            repeat ($urandom_range(0, 5)) cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
